// File: rtl/vga_timing_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Raster timing generator for 1024x768 @ 60 Hz on a 65 MHz pixel
//             clock. This is the first stage of the drawing pipeline. It
//             provides pixel/line counters, blanking and sync flags, and
//             single-cycle line/frame start markers. Every output is
//             registered, and all flags are aligned with the counters they
//             describe.
//  Ports    :
//     clk          in   1   pixel clock
//     rst          in   1   synchronous reset, active-high (overrides en)
//     en           in   1   count enable; low freezes every output
//     hcount       out  CW  horizontal pixel index, 0..H_TOTAL-1
//     vcount       out  CW  line index, 0..V_TOTAL-1
//     hblnk        out  1   high when hcount >= H_ACTIVE
//     vblnk        out  1   high when vcount >= V_ACTIVE
//     hsync        out  1   SYNC_ACT inside the horizontal sync window
//     vsync        out  1   SYNC_ACT inside the vertical sync window
//     line_start   out  1   high while hcount == 0 (after the first wrap)
//     frame_start  out  1   high while hcount == 0 and vcount == 0
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
   parameter int   H_ACTIVE = 1024,
   parameter int   H_FP     = 24,
   parameter int   H_SYNC   = 136,
   parameter int   H_BP     = 160,
   parameter int   V_ACTIVE = 768,
   parameter int   V_FP     = 3,
   parameter int   V_SYNC   = 6,
   parameter int   V_BP     = 29,
   parameter logic SYNC_ACT = 1'b1,
   parameter int   CW       = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          hblnk,
   output logic          vblnk,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start
);

   // ------------------------------------------------------------------------
   // Derived timing constants
   // ------------------------------------------------------------------------
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] c_h_last     = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] c_v_last     = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] c_h_active   = CW'(H_ACTIVE);
   localparam logic [CW-1:0] c_v_active   = CW'(V_ACTIVE);
   localparam logic [CW-1:0] c_hs_first   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] c_hs_last    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] c_vs_first   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] c_vs_last    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [CW-1:0] c_zero       = '0;
   localparam logic [CW-1:0] c_one        = CW'(1);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // ------------------------------------------------------------------------
   generate
      if ((H_TOTAL >= (1 << CW)) || (V_TOTAL >= (1 << CW))) begin : g_bad_cw
         $error("vga_timing_gen: CW too narrow for the line or frame total");
      end
      if ((H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
          (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_bad_porch
         $error("vga_timing_gen: porch and sync widths must be non-zero");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   logic [CW-1:0] hcount_q, hcount_d;
   logic [CW-1:0] vcount_q, vcount_d;
   logic          hblnk_q, hblnk_d;
   logic          vblnk_q, vblnk_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;

   // ------------------------------------------------------------------------
   // Next-state counters
   // ------------------------------------------------------------------------
   logic w_h_wrap;
   logic w_v_wrap;

   assign w_h_wrap = (hcount_q == c_h_last);
   assign w_v_wrap = (vcount_q == c_v_last);

   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (en) begin
         if (w_h_wrap) begin
            hcount_d = c_zero;
            // Line and frame wrap share the same edge, so the frame
            // restarts exactly at (0,0).
            vcount_d = w_v_wrap ? c_zero : (vcount_q + c_one);
         end else begin
            hcount_d = hcount_q + c_one;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Flag decode
   // The flags are decoded from the next-state counters and registered
   // alongside them. This keeps every flag aligned with the hcount/vcount
   // shown in the same cycle. While en is low, all flags hold, and that
   // includes any pulse that happens to be high.
   // ------------------------------------------------------------------------
   always_comb begin
      hblnk_d       = hblnk_q;
      vblnk_d       = vblnk_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      line_start_d  = line_start_q;
      frame_start_d = frame_start_q;
      if (en) begin
         hblnk_d       = (hcount_d >= c_h_active);
         vblnk_d       = (vcount_d >= c_v_active);
         hsync_d       = ((hcount_d >= c_hs_first) && (hcount_d <= c_hs_last))
                         ? SYNC_ACT : ~SYNC_ACT;
         // vsync uses only vcount_d, so it switches on the same edge where
         // hcount wraps to 0.
         vsync_d       = ((vcount_d >= c_vs_first) && (vcount_d <= c_vs_last))
                         ? SYNC_ACT : ~SYNC_ACT;
         line_start_d  = (hcount_d == c_zero);
         frame_start_d = (hcount_d == c_zero) && (vcount_d == c_zero);
      end
   end

   // ------------------------------------------------------------------------
   // Registers. Reset leaves the pulses low even though the counters read
   // (0,0), because no wrap has happened yet.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_q      <= c_zero;
         vcount_q      <= c_zero;
         hblnk_q       <= 1'b0;
         vblnk_q       <= 1'b0;
         hsync_q       <= ~SYNC_ACT;
         vsync_q       <= ~SYNC_ACT;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hblnk_q       <= hblnk_d;
         vblnk_q       <= vblnk_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs come straight from flops
   // ------------------------------------------------------------------------
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign hblnk       = hblnk_q;
   assign vblnk       = vblnk_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. It runs three instances
//             from shared stimulus: the default 1024x768 timing, a shrunken
//             raster (25x14) that fits whole frames into a short run, and the
//             same shrunken raster with active-low sync. A reference model
//             queues the expected outputs each cycle, and those are popped
//             after the edge for comparison.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst;
   logic en;

   always #5 clk = ~clk;

   // default instance
   logic [10:0] hcount_d, vcount_d;
   logic        hblnk_d, vblnk_d, hsync_d, vsync_d, line_start_d, frame_start_d;
   // small instance, active-high sync
   logic [4:0]  hcount_s, vcount_s;
   logic        hblnk_s, vblnk_s, hsync_s, vsync_s, line_start_s, frame_start_s;
   // small instance, active-low sync
   logic [4:0]  hcount_n, vcount_n;
   logic        hblnk_n, vblnk_n, hsync_n, vsync_n, line_start_n, frame_start_n;

   vga_timing_gen u_dflt (
      .clk(clk), .rst(rst), .en(en),
      .hcount(hcount_d), .vcount(vcount_d), .hblnk(hblnk_d), .vblnk(vblnk_d),
      .hsync(hsync_d), .vsync(vsync_d), .line_start(line_start_d),
      .frame_start(frame_start_d)
   );

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
      .SYNC_ACT(1'b1), .CW(5)
   ) u_small (
      .clk(clk), .rst(rst), .en(en),
      .hcount(hcount_s), .vcount(vcount_s), .hblnk(hblnk_s), .vblnk(vblnk_s),
      .hsync(hsync_s), .vsync(vsync_s), .line_start(line_start_s),
      .frame_start(frame_start_s)
   );

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
      .SYNC_ACT(1'b0), .CW(5)
   ) u_neg (
      .clk(clk), .rst(rst), .en(en),
      .hcount(hcount_n), .vcount(vcount_n), .hblnk(hblnk_n), .vblnk(vblnk_n),
      .hsync(hsync_n), .vsync(vsync_n), .line_start(line_start_n),
      .frame_start(frame_start_n)
   );

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hb;
      logic        vb;
      logic        hs;
      logic        vs;
      logic        ls;
      logic        fs;
   } exp_t;

   typedef struct packed {
      exp_t d;
      exp_t s;
      exp_t n;
   } trio_t;

   trio_t sb[$];
   exp_t  m_d = '0;
   exp_t  m_s = '0;
   exp_t  m_n = '0;

   int checks   = 0;
   int failures = 0;

   // Reference model: one clock edge of the raster for a given geometry.
   function automatic exp_t step(input exp_t p, input logic r, input logic e,
                                 input int ha, input int hf, input int hsw, input int hbp,
                                 input int va, input int vf, input int vsw, input int vbp,
                                 input logic act);
      exp_t n;
      int   h, v, ht, vt;
      n  = '0;
      ht = ha + hf + hsw + hbp;
      vt = va + vf + vsw + vbp;
      if (r) begin
         n.hs = ~act;
         n.vs = ~act;
         return n;
      end
      if (!e) return p;
      h = int'(p.h) + 1;
      v = int'(p.v);
      if (h == ht) begin
         h = 0;
         v = v + 1;
         if (v == vt) v = 0;
      end
      n.h  = 11'(h);
      n.v  = 11'(v);
      n.hb = (h >= ha);
      n.vb = (v >= va);
      n.hs = (h >= ha + hf && h < ha + hf + hsw) ? act : ~act;
      n.vs = (v >= va + vf && v < va + vf + vsw) ? act : ~act;
      n.ls = (h == 0);
      n.fs = (h == 0 && v == 0);
      return n;
   endfunction

   task automatic chk_vec(input string tag, input exp_t obs, input exp_t exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue the expected result, then compare
   // after the edge.
   task automatic tick(input logic r, input logic e);
      trio_t t;
      exp_t  o;
      rst = r;
      en  = e;
      m_d = step(m_d, r, e, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b1);
      m_s = step(m_s, r, e, 16, 2, 3, 4, 8, 1, 2, 3, 1'b1);
      m_n = step(m_n, r, e, 16, 2, 3, 4, 8, 1, 2, 3, 1'b0);
      sb.push_back({m_d, m_s, m_n});
      @(posedge clk);
      #1;
      t = sb.pop_front();
      o = {hcount_d, vcount_d, hblnk_d, vblnk_d, hsync_d, vsync_d,
           line_start_d, frame_start_d};
      chk_vec("sb_dflt", o, t.d);
      o = {6'd0, hcount_s, 6'd0, vcount_s, hblnk_s, vblnk_s, hsync_s, vsync_s,
           line_start_s, frame_start_s};
      chk_vec("sb_small", o, t.s);
      o = {6'd0, hcount_n, 6'd0, vcount_n, hblnk_n, vblnk_n, hsync_n, vsync_n,
           line_start_n, frame_start_n};
      chk_vec("sb_neg", o, t.n);
   endtask

   int hb_cnt, hs_cnt, ls_cnt, fs_s_cnt, vs_s_cnt, vmax_s, hd_save;

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);

      // Reset state, with and without enable
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      chk_int("rst_hcount", int'(hcount_d), 0);
      chk_int("rst_vcount", int'(vcount_d), 0);
      chk_int("rst_hsync", int'(hsync_d), 0);
      chk_int("rst_line_start", int'(line_start_d), 0);
      chk_int("rst_frame_start", int'(frame_start_d), 0);
      chk_int("rst_neg_hsync", int'(hsync_n), 1);
      chk_int("rst_neg_vsync", int'(vsync_n), 1);

      // First enabled edge
      tick(1'b0, 1'b1);
      chk_int("first_hcount", int'(hcount_d), 1);
      chk_int("first_vcount", int'(vcount_d), 0);

      // Rest of line 0 on the default raster (cycles 2..1344)
      hb_cnt = 0; hs_cnt = 0; ls_cnt = 0; fs_s_cnt = 0; vs_s_cnt = 0;
      for (int i = 0; i < 1343; i++) begin
         tick(1'b0, 1'b1);
         hb_cnt   += int'(hblnk_d);
         hs_cnt   += int'(hsync_d);
         ls_cnt   += int'(line_start_d);
         fs_s_cnt += int'(frame_start_s);
         vs_s_cnt += int'(vsync_s);
      end
      chk_int("line_hblnk_cycles", hb_cnt, 320);
      chk_int("line_hsync_cycles", hs_cnt, 136);
      chk_int("line_start_count", ls_cnt, 1);
      chk_int("wrap_hcount", int'(hcount_d), 0);
      chk_int("wrap_vcount", int'(vcount_d), 1);
      chk_int("wrap_line_start", int'(line_start_d), 1);
      chk_int("small_frame_starts", fs_s_cnt, 3);
      chk_int("small_vsync_cycles", vs_s_cnt, 200);

      // Freeze while the small raster's line_start is high
      for (int i = 0; i < 30 && !line_start_s; i++) tick(1'b0, 1'b1);
      chk_int("find_line_start", int'(line_start_s), 1);
      hd_save = int'(hcount_d);
      for (int i = 0; i < 50; i++) tick(1'b0, 1'b0);
      chk_int("freeze_line_start", int'(line_start_s), 1);
      chk_int("freeze_hcount", int'(hcount_d), hd_save);
      tick(1'b0, 1'b1);
      chk_int("resume_hcount", int'(hcount_d), hd_save + 1);

      // Reset mid-run with enable high
      for (int i = 0; i < 100; i++) tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      chk_int("midrst_hcount", int'(hcount_d), 0);
      chk_int("midrst_vcount_s", int'(vcount_s), 0);
      chk_int("midrst_line_start", int'(line_start_s), 0);
      chk_int("midrst_neg_vsync", int'(vsync_n), 1);

      // Reset with enable low, then a short hold
      for (int i = 0; i < 37; i++) tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      chk_int("rst_en0_hcount", int'(hcount_s), 0);
      chk_int("rst_en0_vcount", int'(vcount_s), 0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);

      // Two full small frames: vcount peaks at 13, then wraps to 0 with hcount
      fs_s_cnt = 0; vmax_s = 0;
      for (int i = 0; i < 700; i++) begin
         tick(1'b0, 1'b1);
         fs_s_cnt += int'(frame_start_s);
         if (int'(vcount_s) > vmax_s) vmax_s = int'(vcount_s);
      end
      chk_int("frame_start_count", fs_s_cnt, 2);
      chk_int("vcount_peak", vmax_s, 13);
      chk_int("frame_end_hcount", int'(hcount_s), 0);
      chk_int("frame_end_vcount", int'(vcount_s), 0);
      chk_int("frame_end_frame_start", int'(frame_start_s), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 1024x768 @ 60 Hz raster timing on the 65 MHz pixel clock.
- First stage of the top_vga drawing pipeline: every draw stage (background, board, figures, mouse pointer) consumes its counters, sync and blanking outputs.
- Adds single-cycle frame/line markers so downstream stages can latch positions such as mouse xpos/ypos once per frame.
- All outputs are registered; an enable input freezes the raster.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels); line total = 1344
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines); frame total = 806
- SYNC_ACT, 1'b1, active level of hsync/vsync
- CW, 11, counter width; must satisfy 2^CW > both totals

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  synchronous reset, active-high
- en  in  1  count enable; low freezes every output
- hcount  out  CW  horizontal pixel index, 0..H_TOTAL-1
- vcount  out  CW  line index, 0..V_TOTAL-1
- hblnk  out  1  high when hcount >= H_ACTIVE
- vblnk  out  1  high when vcount >= V_ACTIVE
- hsync  out  1  SYNC_ACT while hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
- vsync  out  1  SYNC_ACT while vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- line_start  out  1  one-cycle pulse when hcount==0
- frame_start  out  1  one-cycle pulse when hcount==0 and vcount==0

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high. rst overrides en.
- Reset values (the register state after the rst edge):
  - hcount=0, vcount=0.
  - hblnk=0, vblnk=0.
  - hsync=~SYNC_ACT, vsync=~SYNC_ACT.
  - line_start=0, frame_start=0.
- Counting: the first clock with en=1 after reset produces hcount=1, vcount=0.
  - hcount increments by 1 per enabled cycle.
  - At hcount==H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At hcount==H_TOTAL-1 with vcount==V_TOTAL-1, both wrap to 0 on the same edge.
- Decode timing: hblnk, vblnk, hsync, vsync, line_start and frame_start are registered decodes of the next-state counter values. They are always consistent with the hcount/vcount presented in the same cycle, so there is zero relative skew between counters and flags.
- Exact boundaries with defaults:
  - hblnk rises at hcount=1024 and falls at hcount=0.
  - hsync is active for hcount 1048..1183.
  - vblnk rises at vcount=768.
  - vsync is active for vcount 771..776 on all hcount values; it changes on the same cycle hcount wraps to 0.
- Pulses:
  - line_start is high exactly at hcount==0 of every line, including line 0.
  - frame_start is high only at (0,0).
  - Neither pulse is asserted in the reset-value state, because no wrap has occurred.
  - The first frame_start is seen after a full frame: 1344*806 = 1,083,264 enabled cycles.
- en=0: all outputs hold their values, and a pulse that was high stays high for the duration of the freeze. Designers must gate pulse consumers with en.
- Reset mid-frame: counters return to (0,0) on the next edge regardless of position or en. The outputs match the reset values above.
- Elaboration: an $error is raised if H_TOTAL or V_TOTAL >= 2^CW, or if any porch/sync parameter is 0.
- No combinational path from any input to any output.

Test Plan:
- Reset then en=1 held → first enabled edge gives hcount=1. hcount reaches 1343 then 0 with vcount=1 at cycle 1344. line_start is high exactly once per 1344 cycles.
- Full frame (defaults) → frame_start pulses every 1,083,264 cycles. vcount peaks at 805 and wraps to 0 together with hcount.
- Horizontal decode → hblnk=1 for hcount 1024..1343 (320 cycles/line). hsync=1 for hcount 1048..1183 (136 cycles/line). Checked on lines 0, 500 and 805.
- Vertical decode → vblnk=1 for vcount 768..805. vsync=1 for vcount 771..776, spanning 6*1344 = 8064 cycles. A tiff_writer keyed on vsync captures a 1344x806 image with the active area offset per the sync position.
- Freeze and reset: drop en for 50 cycles at (1100,771) → all outputs are stable during the freeze and counting resumes at 1101. Assert rst at (600,400) → (0,0), sync inactive, pulses 0 on the next edge. rst together with en=0 still resets.
- SYNC_ACT=0 instance → hsync/vsync are low only inside their windows and high after reset. Blanking is unaffected.
